// File: rtl/alu_display_pkg.sv
// Shared field offsets, entry layout and 7-segment table for the ALU result display.
// The entry keeps the ALU flags next to the 4-bit result so one read drives every output.
package alu_display_pkg;

  localparam int SIGN_BIT  = 7;
  localparam int ZERO_BIT  = 6;
  localparam int CARRY_BIT = 5;
  localparam int DONE_BIT  = 4;
  localparam int RESULT_W  = 4;
  localparam int ENTRY_W   = 7;

  typedef struct packed {
    logic                sign;
    logic                zero;
    logic                carry;
    logic [RESULT_W-1:0] result;
  } entry_t;

  // Active-high segments, bit 0 = a ... bit 6 = g, indexed by the hex digit.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic entry_t make_entry(input logic [7:0] alu_byte);
    entry_t e;
    e.sign   = alu_byte[SIGN_BIT];
    e.zero   = alu_byte[ZERO_BIT];
    e.carry  = alu_byte[CARRY_BIT];
    e.result = alu_byte[RESULT_W-1:0];
    return e;
  endfunction

endpackage

// File: rtl/alu_result_display_hex7seg.sv
// Combinational hex digit to 7-segment decoder.
module hex7seg
  import alu_display_pkg::*;
(
  input  logic [RESULT_W-1:0] digit,
  output logic [6:0]          seg
);

  // Table lookup covers all 16 codes, so no fall-through value is needed.
  always_comb begin
    seg = SEG_TABLE[digit];
  end

endmodule

// File: rtl/alu_result_display.sv
// Captures each completed ALU operation into a history ring and displays one entry,
// with a synchronised step button scrolling from newest to oldest.
module alu_result_display
  import alu_display_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       alu_out,
  input  logic             step,
  output logic [6:0]       seg,
  output logic             dp,
  output logic             sign_led,
  output logic             zero_led,
  output logic [IDX_W-1:0] view_idx,
  output logic             valid
);

  localparam int               CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  entry_t           mem [DEPTH];
  logic             done_q;
  logic             capture;
  logic [IDX_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             step_s1;
  logic             step_s2;
  logic             step_s3;
  logic             step_edge;
  logic [CNT_W-1:0] view_inc;
  logic [IDX_W-1:0] view_next;
  logic [IDX_W-1:0] rd_ptr;
  entry_t           viewed;
  logic [6:0]       seg_dec;

  // Capture and step edge detection; capture takes priority over a coincident step.
  always_comb begin
    capture   = alu_out[DONE_BIT] & ~done_q;
    step_edge = step_s2 & ~step_s3;
    view_inc  = {1'b0, view_idx} + CNT_W'(1);
    view_next = view_idx;
    if (capture) begin
      view_next = '0;
    end else if (step_edge && (count != '0)) begin
      if (view_inc >= count) begin
        view_next = '0;
      end else begin
        view_next = view_inc[IDX_W-1:0];
      end
    end else begin
      view_next = view_idx;
    end
  end

  // Newest entry sits just below wr_ptr; older entries walk backwards around the ring.
  always_comb begin
    rd_ptr = wr_ptr - IDX_W'(1) - view_idx;
    viewed = mem[rd_ptr];
  end

  hex7seg u_hex7seg (
    .digit (viewed.result),
    .seg   (seg_dec)
  );

  // Pointers, occupancy, done history and step synchroniser.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q   <= 1'b0;
      wr_ptr   <= '0;
      count    <= '0;
      view_idx <= '0;
      step_s1  <= 1'b0;
      step_s2  <= 1'b0;
      step_s3  <= 1'b0;
    end else begin
      done_q   <= alu_out[DONE_BIT];
      step_s1  <= step;
      step_s2  <= step_s1;
      step_s3  <= step_s2;
      view_idx <= view_next;
      if (capture) begin
        wr_ptr <= wr_ptr + IDX_W'(1);
        if (count != FULL) begin
          count <= count + CNT_W'(1);
        end else begin
          count <= count;
        end
      end else begin
        wr_ptr <= wr_ptr;
        count  <= count;
      end
    end
  end

  // History storage; contents are unreachable until count says otherwise, so no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr] <= make_entry(alu_out);
    end
  end

  // Registered display outputs, blanked while the history is empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg      <= 7'h00;
      dp       <= 1'b0;
      sign_led <= 1'b0;
      zero_led <= 1'b0;
      valid    <= 1'b0;
    end else if (count == '0) begin
      seg      <= 7'h00;
      dp       <= 1'b0;
      sign_led <= 1'b0;
      zero_led <= 1'b0;
      valid    <= 1'b0;
    end else begin
      seg      <= seg_dec;
      dp       <= viewed.carry;
      sign_led <= viewed.sign;
      zero_led <= viewed.zero;
      valid    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboard bench: stimulus tasks push expected display states from a history-queue
// model; a negedge monitor pops and compares them against the DUT outputs.
module tb_alu_result_display;

  localparam int DEPTH = 4;
  localparam int IDX_W = 2;

  logic             clk;
  logic             reset;
  logic [7:0]       alu_out;
  logic             step;
  logic [6:0]       seg;
  logic             dp;
  logic             sign_led;
  logic             zero_led;
  logic [IDX_W-1:0] view_idx;
  logic             valid;

  alu_result_display #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_out  (alu_out),
    .step     (step),
    .seg      (seg),
    .dp       (dp),
    .sign_led (sign_led),
    .zero_led (zero_led),
    .view_idx (view_idx),
    .valid    (valid)
  );

  typedef struct {
    int         due;
    logic [6:0] seg;
    logic       dp;
    logic       sgn;
    logic       zro;
    logic       vld;
    logic [1:0] vidx;
  } exp_t;

  logic [6:0] seg_ref [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  exp_t       sb [$];
  logic [7:0] hist [$];
  int         view;
  int         cyc;
  int         passed;
  int         total;
  exp_t       e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: newest-first list of captured bytes and an age index.
  function automatic void model_clear();
    hist.delete();
    view = 0;
  endfunction

  function automatic void model_capture(input logic [7:0] v);
    hist.push_front(v);
    if (hist.size() > DEPTH) void'(hist.pop_back());
    view = 0;
  endfunction

  function automatic void model_step();
    if (hist.size() > 0) view = (view + 1) % hist.size();
  endfunction

  function automatic void push_exp();
    exp_t x;
    logic [7:0] b;
    x.due = cyc;
    if (hist.size() == 0) begin
      x.seg = 7'h00; x.dp = 1'b0; x.sgn = 1'b0; x.zro = 1'b0; x.vld = 1'b0; x.vidx = 2'd0;
    end else begin
      b = hist[view];
      x.seg = seg_ref[b[3:0]]; x.dp = b[5]; x.sgn = b[7]; x.zro = b[6];
      x.vld = 1'b1; x.vidx = 2'(view);
    end
    sb.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    else passed++;
  endtask

  // Monitor: compare every expectation that has fallen due.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("seg",      {1'b0, seg},      {1'b0, e.seg});
      chk("dp",       {7'b0, dp},       {7'b0, e.dp});
      chk("sign_led", {7'b0, sign_led}, {7'b0, e.sgn});
      chk("zero_led", {7'b0, zero_led}, {7'b0, e.zro});
      chk("valid",    {7'b0, valid},    {7'b0, e.vld});
      chk("view_idx", {6'b0, view_idx}, {6'b0, e.vidx});
    end
  end

  task automatic capture(input logic [7:0] v, input int hold);
    alu_out = v | 8'h10;
    @(posedge clk); #1;
    model_capture(v);
    @(posedge clk); #1;
    push_exp();
    repeat (hold) @(posedge clk);
    #1;
    alu_out = 8'($urandom) & 8'hEF;
    @(posedge clk); #1;
  endtask

  task automatic do_step();
    step = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_step();
    @(posedge clk); #1;
    push_exp();
    step = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // done rises so that it is sampled on the same edge that sees the synchronised step edge.
  task automatic collide(input logic [7:0] v);
    step = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    alu_out = v | 8'h10;
    @(posedge clk); #1;
    model_capture(v);
    @(posedge clk); #1;
    push_exp();
    alu_out = 8'($urandom) & 8'hEF;
    step = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    #1 reset = 1'b0;
    model_clear();
    push_exp();
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] rnd_byte(input logic [3:0] res);
    return (8'($urandom) & 8'hE0) | {4'h0, res};
  endfunction

  initial begin
    cyc = 0; passed = 0; total = 0; view = 0;
    reset = 1'b0; alu_out = 8'h00; step = 1'b0;

    // Reset held with random inputs, then released with done low.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      alu_out = 8'($urandom); step = 1'($urandom);
      push_exp();
    end
    alu_out = 8'($urandom) & 8'hEF; step = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      step = 1'($urandom);
      push_exp();
    end
    step = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Single capture with done held high, then a step that must not move.
    capture(8'h35, 10);
    push_exp();
    do_step();

    // Fill and wrap.
    reset_pulse();
    capture(rnd_byte(4'h1), 0);
    capture(rnd_byte(4'h2), 0);
    capture(rnd_byte(4'h3), 0);
    capture(rnd_byte(4'h4), 1);
    capture(rnd_byte(4'hF), 0);
    for (int i = 0; i < 4; i++) do_step();

    // Flags.
    capture(8'hD0, 0);

    // Capture vs step collision from view_idx 2.
    reset_pulse();
    for (int i = 0; i < 3; i++) capture(8'($urandom), 0);
    do_step();
    do_step();
    collide(8'($urandom));

    // Reset mid-history.
    reset_pulse();
    for (int i = 0; i < 3; i++) capture(8'($urandom), 0);
    do_step();
    reset_pulse();
    capture(8'h09, 0);
    do_step();

    // Randomised mix.
    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4) capture(8'($urandom), int'($urandom_range(0, 3)));
      else if (r < 8) do_step();
      else collide(8'($urandom));
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if (sb.size() != 0) $display("FAIL drain: got %0d pending required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_result_display.md
# alu_result_display

Downstream consumer of the 4-bit sequential ALU output byte `{sign, zero, carry, done, result[3:0]}`. It detects each completed operation (rising edge of `done`) and captures the result and flags into a small history ring buffer. It drives a 7-segment digit, decimal point and flag LEDs. A debounced-externally `step` button scrolls back through the stored history.

## Interface
Parameters:
- `DEPTH`, 4, number of history entries; power of two, 2..8.
- `IDX_W`, $clog2(DEPTH), width of the entry index.

Ports:
- `clk`  in  1  single clock for the block.
- `reset`  in  1  asynchronous, active-low reset; all state clears while low.
- `alu_out`  in  8  ALU output byte:
  - [7] sign
  - [6] zero
  - [5] carry
  - [4] done
  - [3:0] result
- `step`  in  1  asynchronous button level; each rising edge views one entry older.
- `seg`  out  7  segment drive, active-high; [0]=a … [6]=g.
- `dp`  out  1  carry flag of the viewed entry.
- `sign_led`  out  1  sign flag of the viewed entry.
- `zero_led`  out  1  zero flag of the viewed entry.
- `view_idx`  out  IDX_W  age of the viewed entry; 0 = newest.
- `valid`  out  1  at least one entry is stored.

## Operation
- **Capture**
  - `done_q` is a register holding the previous `alu_out[4]`.
  - Capture fires when `alu_out[4] & ~done_q`. `alu_out` comes from the same clock domain, so it is not synchronised.
  - On capture, `{alu_out[7:5], alu_out[3:0]}` (7 bits) is written at `wr_ptr`.
  - `wr_ptr` increments mod DEPTH.
  - `count` increments, saturating at DEPTH.
  - When full, the oldest entry is overwritten; `count` stays at DEPTH.
  - `view_idx` is forced to 0.
- **Done level behaviour**
  - `done` held high across many cycles produces exactly one capture.
  - A new capture requires `done` to drop and rise again. The ALU clears `done` when it fetches its first operand.
- **Step**
  - `step` passes through a 2-FF synchroniser, then a third flop for edge detection.
  - Each synchronised rising edge sets `view_idx <= (view_idx + 1) mod count`.
  - Step is ignored while `count == 0`.
  - With `count == 1`, `view_idx` stays 0.
- **Viewed entry**
  - The entry shown is `mem[(wr_ptr - 1 - view_idx) mod DEPTH]`.
- **Simultaneous capture and step edge**
  - Capture wins; `view_idx = 0`, and the step edge is dropped.
- **Display**
  - The hex decoder maps the viewed result to `seg`:
    - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07
    - 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71
  - `dp`, `sign_led` and `zero_led` reflect the viewed entry's flags.
  - While `count == 0`: `seg=0`, `dp=0`, `sign_led=0`, `zero_led=0`, `valid=0`.
- **Reset (async, `reset` low)**
  - Cleared: `wr_ptr`, `count`, `view_idx`, `done_q`, synchroniser flops, all outputs.
  - Memory contents are don't-care; they are unreachable because `count=0`.
  - Reset asserted mid-stream discards all history.
  - Release is synchronous to `clk` via the normal flop recovery.

## Timing
- **Capture latency**
  - Let edge N be the first edge where `done` is sampled high after being low at edge N-1.
  - The entry is written at edge N.
  - `seg`, `dp`, `sign_led`, `zero_led` and `valid` are registered outputs and show the new entry after edge N+1.
- **Step latency**
  - Let edge N be the first edge that samples `step` high (sync1).
  - sync2 is set at N+1, the edge is detected, and `view_idx` updates at N+2.
  - Display outputs update at N+3.
  - `view_idx` itself is registered, so it is visible after N+2.
- **Capture throughput**
  - One capture per `done` pulse.
  - Back-to-back rising edges need at least one low cycle between them.

## Structure
- Shared package `alu_display_pkg`:
  - localparam field offsets within `alu_out`: `SIGN_BIT=7`, `ZERO_BIT=6`, `CARRY_BIT=5`, `DONE_BIT=4`.
  - `RESULT_W=4`.
  - `ENTRY_W=7`.
  - The 16-entry segment constant table.
- One sub-module: `hex7seg`, a combinational 4-bit to 7-segment decoder.
- The top level holds the ring buffer, the pointers and the synchroniser.

## Test plan
1. **Reset:** hold `reset` low with random `alu_out` and `step`.
   - Required: `seg=0`, `dp=0`, `valid=0`, `view_idx=0`.
   - After release, with no `done` pulse, the outputs stay the same.
2. **Single capture:** drive `alu_out=0x35` (carry=1, done=1, result=5), then hold it for 10 cycles.
   - Required, 2 edges after the rise: `seg=0x6D`, `dp=1`, `valid=1`.
   - Exactly one entry is stored; `count=1`.
3. **Fill and wrap:** issue 5 done pulses with results 1, 2, 3, 4, 0xF (DEPTH=4).
   - Newest shows `seg=0x71`.
   - 3 step edges walk through 4, 3, 2, showing `seg` 0x66, 0x4F, 0x5B.
   - A 4th step wraps back to 0xF.
   - Result 1 has been overwritten.
4. **Flags:** capture `alu_out=0xD0` (sign=1, zero=1, done=1, result=0).
   - Required: `sign_led=1`, `zero_led=1`, `dp=0`, `seg=0x3F`.
5. **Capture vs step collision:** with `view_idx=2`, make a `done` rising edge coincide with the synchronised step edge.
   - Required: `view_idx=0`, and the new entry is displayed.
6. **Reset mid-history:** with 3 entries stored and `view_idx=1`, pulse `reset` low asynchronously between clock edges.
   - Required: `valid=0` and `seg=0` immediately.
   - A subsequent capture of result 9 shows `seg=0x6F` with `count=1`.
